// File: rtl/key_pkg.sv
// Shared types and constants for the keypad emulator.
// State encodings, idle row level and key-code field helpers.
package key_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_P_BNC = 3'd1,
    S_HOLD  = 3'd2,
    S_R_BNC = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] ROW_IDLE = 4'b1111;

  localparam int KEY_ROW_HI = 3;
  localparam int KEY_ROW_LO = 2;
  localparam int KEY_COL_HI = 1;
  localparam int KEY_COL_LO = 0;

  function automatic logic [1:0] key_row(
    input logic [3:0] k
  );
    return k[KEY_ROW_HI:KEY_ROW_LO];
  endfunction

  function automatic logic [1:0] key_col(
    input logic [3:0] k
  );
    return k[KEY_COL_HI:KEY_COL_LO];
  endfunction

endpackage

// File: rtl/key_matrix_net.sv
// Switch network: closed contact shorts one column onto one row.
// Purely combinational so the scanner sees zero clock latency.
module key_matrix_net
  import key_pkg::*;
(
  input  logic       contact,
  input  logic [3:0] key_q,
  input  logic [3:0] col,
  output logic [3:0] row
);

  always_comb begin
    row = ROW_IDLE;
    if (contact)
      row[key_row(key_q)] = col[key_col(key_q)];
  end

endmodule

// File: rtl/key_matrix_emu.sv
// 4x4 keypad emulator: presses one key with bounce, hold, release.
// FSM and counters here; the col->row short lives in key_matrix_net.
module key_matrix_emu
  import key_pkg::*;
#(
  parameter int BOUNCE_CYC = 8,
  parameter int BOUNCE_N   = 4,
  parameter int HOLD_CYC   = 500,
  parameter int CNT_W      = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [3:0] key,
  output logic       ready,
  output logic       busy,
  output logic       done,
  input  logic [3:0] col,
  output logic [3:0] row
);

  localparam int PER_W =
    (BOUNCE_N > 1) ? $clog2(BOUNCE_N) : 1;
  localparam int PER_L =
    (BOUNCE_N > 0) ? BOUNCE_N - 1 : 0;

  localparam logic [CNT_W-1:0] BNC_LAST =
    CNT_W'(BOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(HOLD_CYC - 1);
  localparam logic [PER_W-1:0] PER_LAST =
    PER_W'(PER_L);

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] cyc_cnt;
  logic [PER_W-1:0] per_cnt;
  logic [3:0]       key_q;
  logic             contact;
  logic             bnc_end;
  logic             per_end;
  logic             in_bnc;

  assign bnc_end = (cyc_cnt == BNC_LAST);
  assign per_end = bnc_end && (per_cnt == PER_LAST);
  assign in_bnc  = (state == S_P_BNC) ||
                   (state == S_R_BNC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:
        if (req)
          state_d = (BOUNCE_N == 0) ? S_HOLD
                                    : S_P_BNC;
      S_P_BNC:
        if (per_end)
          state_d = S_HOLD;
      S_HOLD:
        if (cyc_cnt == HOLD_LAST)
          state_d = (BOUNCE_N == 0) ? S_DONE
                                    : S_R_BNC;
      S_R_BNC:
        if (per_end)
          state_d = S_DONE;
      S_DONE:
        state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // Counters restart from zero on every state entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_cnt <= '0;
      per_cnt <= '0;
      key_q   <= '0;
    end else begin
      if (state == S_IDLE && req)
        key_q <= key;
      if (state_d != state) begin
        cyc_cnt <= '0;
        per_cnt <= '0;
      end else if (state == S_HOLD) begin
        cyc_cnt <= cyc_cnt + 1'b1;
      end else if (in_bnc) begin
        if (bnc_end) begin
          cyc_cnt <= '0;
          per_cnt <= per_cnt + 1'b1;
        end else begin
          cyc_cnt <= cyc_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    ready   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    contact = 1'b0;
    unique case (1'b1)
      (state == S_IDLE): ready = 1'b1;
      (state == S_P_BNC): begin
        busy    = 1'b1;
        contact = ~per_cnt[0];
      end
      (state == S_HOLD): begin
        busy    = 1'b1;
        contact = 1'b1;
      end
      (state == S_R_BNC): begin
        busy    = 1'b1;
        contact = per_cnt[0];
      end
      (state == S_DONE): begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  key_matrix_net u_net (
    .contact (contact),
    .key_q   (key_q),
    .col     (col),
    .row     (row)
  );

endmodule

// File: tb/tb_key_matrix_emu.sv
// Bench for key_matrix_emu: two instances (bounce on / bounce off)
// driven alike, each checked against its own queue of expected cycles.
module tb_key_matrix_emu;

  localparam int BC = 2;
  localparam int BN = 4;
  localparam int HC = 10;

  typedef struct {
    bit         contact;
    bit         done;
    bit         busy;
    logic [3:0] key;
  } exp_t;

  logic       clk = 0;
  logic       rst = 0;
  logic       req = 0;
  logic [3:0] key = 0;
  logic [3:0] col = 4'hF;

  logic       a_ready, a_busy, a_done;
  logic [3:0] a_row;
  logic       b_ready, b_busy, b_done;
  logic [3:0] b_row;

  exp_t qa[$];
  exp_t qb[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_matrix_emu #(
    .BOUNCE_CYC (BC),
    .BOUNCE_N   (BN),
    .HOLD_CYC   (HC),
    .CNT_W      (16)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .key   (key),
    .ready (a_ready),
    .busy  (a_busy),
    .done  (a_done),
    .col   (col),
    .row   (a_row)
  );

  key_matrix_emu #(
    .BOUNCE_CYC (BC),
    .BOUNCE_N   (0),
    .HOLD_CYC   (HC),
    .CNT_W      (16)
  ) dut0 (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .key   (key),
    .ready (b_ready),
    .busy  (b_busy),
    .done  (b_done),
    .col   (col),
    .row   (b_row)
  );

  task automatic cmp(string nm, logic [3:0] got,
                     logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h want %h",
               nm, $time, got, exp);
    end
  endtask

  // Contact state k cycles after acceptance, from the phase rules.
  function automatic bit contact_at(int k, int bn);
    int p = bn * BC;
    if (k <= p)
      return ((k - 1) / BC) % 2 == 0;
    if (k <= p + HC)
      return 1'b1;
    if (k <= 2 * p + HC)
      return ((k - p - HC - 1) / BC) % 2 == 1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] erow(bit c,
      logic [3:0] k, logic [3:0] cl);
    logic [3:0] r = 4'hF;
    int ri = int'(k) / 4;
    int ci = int'(k) % 4;
    if (c) r[ri] = cl[ci];
    return r;
  endfunction

  function automatic exp_t mk(int k, int bn,
                              logic [3:0] kc);
    exp_t e;
    int   last = 2 * bn * BC + HC + 1;
    e.contact = contact_at(k, bn);
    e.done    = (k == last);
    e.busy    = (k <= last);
    e.key     = kc;
    return e;
  endfunction

  task automatic cyc(bit r, logic [3:0] k,
                     logic [3:0] c);
    @(negedge clk);
    #1;
    req = r;
    key = k;
    col = c;
    if (r && qa.size() == 0)
      for (int i = 1; i <= 2 * BN * BC + HC + 2; i++)
        qa.push_back(mk(i, BN, k));
    if (r && qb.size() == 0)
      for (int i = 1; i <= HC + 2; i++)
        qb.push_back(mk(i, 0, k));
  endtask

  task automatic hit_rst();
    @(posedge clk);
    #2 rst = 1;
    #1;
    cmp("rst_row_a", a_row, 4'hF);
    cmp("rst_ready_a", {3'b0, a_ready}, 4'h1);
    cmp("rst_busy_a", {3'b0, a_busy}, 4'h0);
    cmp("rst_done_a", {3'b0, a_done}, 4'h0);
    cmp("rst_row_b", b_row, 4'hF);
    cmp("rst_ready_b", {3'b0, b_ready}, 4'h1);
    qa.delete();
    qb.delete();
    @(negedge clk);
    #1 rst = 0;
  endtask

  // Monitor: each cycle pop one expected cycle per DUT, or expect idle.
  always @(negedge clk) begin
    exp_t e;
    e = '{contact: 1'b0, done: 1'b0,
          busy: 1'b0, key: 4'h0};
    if (qa.size() != 0) e = qa.pop_front();
    cmp("row_a", a_row, erow(e.contact, e.key, col));
    cmp("done_a", {3'b0, a_done}, {3'b0, e.done});
    cmp("busy_a", {3'b0, a_busy}, {3'b0, e.busy});
    cmp("ready_a", {3'b0, a_ready}, {3'b0, !e.busy});
    e = '{contact: 1'b0, done: 1'b0,
          busy: 1'b0, key: 4'h0};
    if (qb.size() != 0) e = qb.pop_front();
    cmp("row_b", b_row, erow(e.contact, e.key, col));
    cmp("done_b", {3'b0, b_done}, {3'b0, e.done});
    cmp("busy_b", {3'b0, b_busy}, {3'b0, e.busy});
    cmp("ready_b", {3'b0, b_ready}, {3'b0, !e.busy});
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    col = 4'($urandom);
    #1 rst = 1;
    #1;
    cmp("init_row_a", a_row, 4'hF);
    cmp("init_ready_a", {3'b0, a_ready}, 4'h1);
    cmp("init_busy_a", {3'b0, a_busy}, 4'h0);
    cmp("init_done_a", {3'b0, a_done}, 4'h0);
    cmp("init_row_b", b_row, 4'hF);
    @(negedge clk);
    #1 rst = 0;

    cyc(1, 4'd5, 4'b1101);
    repeat (32) cyc(0, 4'd5, 4'b1101);

    cyc(1, 4'd5, 4'hF);
    repeat (32) cyc(0, 4'd5, 4'hF);

    cyc(1, 4'd10, 4'b1011);
    repeat (4) cyc(0, 4'd10, 4'b1011);
    cyc(1, 4'd3, 4'b1011);
    repeat (32) cyc(0, 4'd3, 4'b1011);

    cyc(1, 4'd15, 4'b0111);
    repeat (32) cyc(0, 4'd15, 4'b0111);

    cyc(1, 4'd6, 4'h0);
    repeat (11) cyc(0, 4'd6, 4'h0);
    hit_rst();
    repeat (4) cyc(0, 4'd6, 4'h0);

    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(0, 7) == 0,
          4'($urandom), 4'($urandom));

    repeat (40) cyc(0, 4'h0, 4'hF);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/key_matrix_emu.md
# key_matrix_emu

Synthesizable 4x4 matrix-keypad emulator. It is the responder side of the keypad scan interface: it watches the scanner's active-low column drive and returns row lines as a physical switch would. On a request it "presses" one key through three phases (contact bounce, stable hold, release bounce) and then reports completion. It sits between a stimulus source (bench sequencer or on-board test controller) and `key_scan`, so the scanner can be exercised in-system with repeatable press timing.

## Interface

Parameters:
- `BOUNCE_CYC`, default 8: clk cycles per bounce period; must be ≥1.
- `BOUNCE_N`, default 4: number of bounce periods per edge; 0 disables bounce.
- `HOLD_CYC`, default 500: clk cycles of stable closed contact; must be ≥1.
- `CNT_W`, default 16: cycle counter width; must hold max(BOUNCE_CYC, HOLD_CYC)−1.

Ports:
- `clk`, in, 1: single clock; all state is on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req`, in, 1: press request; accepted only when `ready`=1.
- `key`, in, 4: key code 0–15, captured on acceptance.
- `ready`, out, 1: idle and able to accept `req`.
- `busy`, out, 1: a press sequence is in progress.
- `done`, out, 1: single-cycle pulse when a sequence ends.
- `col`, in, 4: column drive from the scanner, active-low.
- `row`, out, 4: row sense to the scanner, active-low, idle 4'b1111.

## Operation

- Key mapping: `r = key_q[3:2]`, `c = key_q[1:0]`. While the contact is closed, `row[r] = col[c]` and all other row bits are 1. While the contact is open, `row = 4'b1111`.
- The `col`→`row` path is combinational, like a real switch. The only registered input to that path is `contact`.
- FSM states: IDLE, P_BNC, HOLD, R_BNC, DONE.
  - IDLE: `ready`=1, `contact`=0. On `req`=1, latch `key` into `key_q` and go to P_BNC, or to HOLD if BOUNCE_N=0.
  - P_BNC: BOUNCE_N periods of BOUNCE_CYC cycles each. `contact` is 1 in even periods (0, 2, …) and 0 in odd periods. Then go to HOLD.
  - HOLD: `contact`=1 for HOLD_CYC cycles. Then go to R_BNC, or to DONE if BOUNCE_N=0.
  - R_BNC: BOUNCE_N periods. `contact` is 0 in even periods and 1 in odd periods. Then go to DONE.
  - DONE: one cycle with `done`=1 and `contact`=0. Then go to IDLE.
- `busy`=1 in P_BNC, HOLD, R_BNC and DONE. `ready` = (state==IDLE).
- `req` is ignored while not in IDLE. `key` changes after acceptance have no effect.
- Counters:
  - `cyc_cnt` (CNT_W bits) counts up from 0 to (BOUNCE_CYC−1 or HOLD_CYC−1), then clears.
  - `per_cnt` counts bounce periods from 0 to BOUNCE_N−1.
  - Both counters clear on every state entry.
- Reset, whenever asserted including mid-sequence: state=IDLE, `contact`=0, `key_q`=0, counters cleared. No `done` pulse is produced for an aborted sequence.

## Timing

- Reset values: `row`=4'b1111, `ready`=1, `busy`=0, `done`=0. Reset applies asynchronously in the same cycle it is asserted.
- `req` is sampled at edge T. From T+1 the state is P_BNC and `ready`=0.
- Phase windows, with P = BOUNCE_N·BOUNCE_CYC:
  - P_BNC: T+1 … T+P.
  - HOLD: T+P+1 … T+P+HOLD_CYC.
  - R_BNC: the next P cycles.
  - DONE: T+2P+HOLD_CYC+1.
  - `ready`=1 again one cycle after DONE.
- Minimum request spacing: 2P+HOLD_CYC+2 cycles.
- `row` follows `col` with zero clock latency while `contact`=1.

## Structure

- Shared package `key_pkg`:
  - FSM state encodings.
  - `ROW_IDLE` = 4'b1111.
  - Key-code field positions (row index = bits 3:2, column index = bits 1:0).
- One sub-module, `key_matrix_net`: purely combinational; inputs `contact`, `key_q` and `col`, output `row`. The FSM and counters stay in the top module.

## Test plan

Parameters for all scenarios: BOUNCE_CYC=2, BOUNCE_N=4, HOLD_CYC=10, except where noted.

- Reset: assert `rst` with arbitrary `col` → `row`=4'hF, `ready`=1, `busy`=0, `done`=0 immediately.
- Key 5, `col`=4'b1101 held, `req` at T:
  - `row`=4'b1101 at T+1–2 and T+5–6.
  - `row`=4'hF at T+3–4 and T+7–8.
  - `row`=4'b1101 at T+9–18.
  - `row`=4'hF at T+19–20 and T+23–24.
  - `row`=4'b1101 at T+21–22 and T+25–26.
  - `done`=1 only at T+27; `ready`=1 at T+28.
- Key 5 with `col`=4'hF (scanner not driving) → `row` stays 4'hF throughout, `busy`=1, and `done` still pulses at T+27.
- Key 10 accepted at T; at T+5 apply `req`=1 with `key`=3 → second request ignored. In HOLD, `col`=4'b1011 gives `row`=4'b1011. Exactly one `done` pulse.
- Assert `rst` at T+12 during HOLD → `row`=4'hF in the same cycle, `ready`=1 after release, and no `done` pulse.
- BOUNCE_N=0, key 15, `col`=4'b0111, `req` at T → `row`=4'b0111 at T+1–10, `done` at T+11.
